// File: rtl/approx_div_sched_pkg.sv
// Shared types and constants for the approximate-divider scheduler.
package approx_div_sched_pkg;

  // Scheduler control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operand and result widths of the 16/8 divider array
  localparam int N_W = 16;
  localparam int D_W = 8;
  localparam int Q_W = 8;

  // Quotient reported for divide-by-zero and quotient-overflow requests
  localparam logic [Q_W-1:0] Q_SAT = 8'hFF;

endpackage

// File: rtl/approx_div_scheduler_if.sv
// Bus bundle between requesters, response consumer, divider array and the scheduler.
interface approx_div_scheduler_if
  import approx_div_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  // Request side, one lane per requester
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [N_W*NUM_REQ-1:0] req_n;
  logic [D_W*NUM_REQ-1:0] req_d;

  // Response side
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [Q_W-1:0]         rsp_q;
  logic [Q_W-1:0]         rsp_r;
  logic                   rsp_dz;
  logic                   rsp_ovf;

  // Shared divider array connection
  logic [N_W-1:0]         div_n;
  logic [D_W-1:0]         div_d;
  logic [Q_W-1:0]         div_q;
  logic [Q_W-1:0]         div_r;

  logic                   busy;

  // Environment side: requesters, consumer and divider array
  modport master (
    output req_valid, req_n, req_d, rsp_ready, div_q, div_r,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf,
           div_n, div_d, busy
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_n, req_d, rsp_ready, div_q, div_r,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf,
           div_n, div_d, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_vld
);

  // cand[k] is the requester index visited at rotation offset k from ptr
  logic [ID_W-1:0] cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum       = {1'b0, ptr} + (ID_W+1)'(gi);
      assign cand[gi]  = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                     : sum[ID_W-1:0];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest valid requester wins
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[k];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = grant_vld && (grant_idx == ID_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/approx_div_scheduler.sv
// Time-shares one external 16/8 combinational divider array between NUM_REQ
// requesters: round-robin grant, operand hold for SETTLE_CYC cycles, result
// capture and a held response. Zero divisors and quotients that would not fit
// in 8 bits are answered directly without touching the array.
module approx_div_scheduler
  import approx_div_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 3,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_div_scheduler_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t           state_q,  state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [N_W-1:0]   n_q,      n_d;
  logic [D_W-1:0]   d_q,      d_d;
  logic [ID_W-1:0]  id_q,     id_d;
  logic [Q_W-1:0]   q_q,      q_d;
  logic [Q_W-1:0]   r_q,      r_d;
  logic             dz_q,     dz_d;
  logic             ovf_q,    ovf_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_vld;
  logic [N_W-1:0]     sel_n;
  logic [D_W-1:0]     sel_d;
  logic               sel_dz;
  logic               sel_ovf;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  // Operands of the requester currently winning arbitration and their early-out flags
  always_comb begin
    sel_n   = bus.req_n[N_W*arb_idx +: N_W];
    sel_d   = bus.req_d[D_W*arb_idx +: D_W];
    sel_dz  = (sel_d == '0);
    sel_ovf = !sel_dz && (sel_n[N_W-1:N_W-D_W] >= sel_d);
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    d_d      = d_q;
    id_d     = id_q;
    q_d      = q_q;
    r_d      = r_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          id_d     = arb_idx;
          rr_ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
          if (sel_dz || sel_ovf) begin
            // Early-out answers leave the array operands alone so div_n/div_d
            // do not toggle for requests the array never evaluates.
            dz_d    = sel_dz;
            ovf_d   = sel_ovf;
            q_d     = Q_SAT;
            r_d     = sel_n[Q_W-1:0];
            state_d = RESP;
          end else begin
            n_d     = sel_n;
            d_d     = sel_d;
            cnt_d   = CNT_W'(SETTLE_CYC - 1);
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          q_d     = bus.div_q;
          r_d     = bus.div_r;
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      d_q      <= '0;
      id_q     <= '0;
      q_q      <= '0;
      r_q      <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      d_q      <= d_d;
      id_q     <= id_d;
      q_q      <= q_d;
      r_q      <= r_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.req_ready = arb_grant & {NUM_REQ{state_q == IDLE}};
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_q     = q_q;
  assign bus.rsp_r     = r_q;
  assign bus.rsp_dz    = dz_q;
  assign bus.rsp_ovf   = ovf_q;
  assign bus.div_n     = n_q;
  assign bus.div_d     = d_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_approx_div_scheduler.sv
// Self-checking bench for approx_div_scheduler with an exact divider array model.
module tb_approx_div_scheduler;

  localparam int NUM_REQ    = 4;
  localparam int SETTLE_CYC = 3;
  localparam int ID_W       = 2;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [7:0]      q;
    logic [7:0]      r;
    logic            dz;
    logic            ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;

  exp_t sb[$];
  int   acc_id_q[$];
  int   acc_cyc_q[$];

  approx_div_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus_if ();

  approx_div_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .SETTLE_CYC (SETTLE_CYC),
    .ID_W       (ID_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Exact combinational divider array
  always_comb begin
    if (bus_if.div_d == 8'd0) begin
      bus_if.div_q = 8'd0;
      bus_if.div_r = 8'd0;
    end else begin
      bus_if.div_q = 8'(bus_if.div_n / {8'd0, bus_if.div_d});
      bus_if.div_r = 8'(bus_if.div_n % {8'd0, bus_if.div_d});
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int id, input logic [15:0] n, input logic [7:0] d);
    exp_t e;
    e.id  = ID_W'(id);
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    if (d == 8'd0) begin
      e.dz = 1'b1;
      e.q  = 8'hFF;
      e.r  = n[7:0];
    end else if (n[15:8] >= d) begin
      e.ovf = 1'b1;
      e.q   = 8'hFF;
      e.r   = n[7:0];
    end else begin
      e.q = 8'(n / {8'd0, d});
      e.r = 8'(n % {8'd0, d});
    end
    return e;
  endfunction

  // Accept monitor: record grants and push expected responses
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus_if.req_valid[i] && bus_if.req_ready[i]) begin
          sb.push_back(model(i, bus_if.req_n[16*i +: 16], bus_if.req_d[8*i +: 8]));
          acc_id_q.push_back(i);
          acc_cyc_q.push_back(cyc);
          $display("accept id=%0d n=0x%04h d=0x%02h cycle=%0d", i,
                   bus_if.req_n[16*i +: 16], bus_if.req_d[8*i +: 8], cyc);
        end
      end
    end
  end

  // Response monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    if (!rst && bus_if.rsp_valid && bus_if.rsp_ready) begin
      check_val("rsp_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        $display("response id=%0d q=0x%02h r=0x%02h dz=%0b ovf=%0b cycle=%0d", bus_if.rsp_id,
                 bus_if.rsp_q, bus_if.rsp_r, bus_if.rsp_dz, bus_if.rsp_ovf, cyc);
        check_val("rsp_id", bus_if.rsp_id, e.id);
        check_val("rsp_q", bus_if.rsp_q, e.q);
        check_val("rsp_r", bus_if.rsp_r, e.r);
        check_val("rsp_dz", bus_if.rsp_dz, e.dz);
        check_val("rsp_ovf", bus_if.rsp_ovf, e.ovf);
      end
    end
  end

  // Drive one request until accepted, then drop valid; returns at posedge+1
  task automatic issue(input int idx, input logic [15:0] n, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    bus_if.req_valid[idx]       = 1'b1;
    bus_if.req_n[16*idx +: 16]  = n;
    bus_if.req_d[8*idx +: 8]    = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus_if.req_ready[idx]) ok = 1'b1;
    end
    check_val("accept_seen", ok, 1);
    @(posedge clk); #1;
    bus_if.req_valid[idx] = 1'b0;
  endtask

  // Count cycles from accept until rsp_valid rises (starts right after issue)
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      lat++;
      if (bus_if.rsp_valid) break;
    end
    check_val("rsp_seen", bus_if.rsp_valid, 1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!bus_if.busy) break;
    end
    check_val("idle_seen", bus_if.busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rsp_valid"}, bus_if.rsp_valid, 0);
    check_val({tag, "_req_ready"}, bus_if.req_ready, 0);
    check_val({tag, "_busy"}, bus_if.busy, 0);
    check_val({tag, "_rsp_id"}, bus_if.rsp_id, 0);
    check_val({tag, "_rsp_q"}, bus_if.rsp_q, 0);
    check_val({tag, "_rsp_r"}, bus_if.rsp_r, 0);
    check_val({tag, "_flags"}, {bus_if.rsp_dz, bus_if.rsp_ovf}, 0);
    check_val({tag, "_div_n"}, bus_if.div_n, 0);
    check_val({tag, "_div_d"}, bus_if.div_d, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    rst      = 1'b1;
    bus_if.req_valid = '0;
    bus_if.req_n     = '0;
    bus_if.req_d     = '0;
    bus_if.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // 1: normal division, latency SETTLE_CYC+1
    issue(0, 16'd100, 8'd7);
    wait_rsp(lat);
    check_val("t1_latency", lat, SETTLE_CYC + 1);
    wait_idle();

    // 2: divide by zero, latency 1, array operands untouched
    issue(2, 16'h1234, 8'd0);
    wait_rsp(lat);
    check_val("t2_latency", lat, 1);
    check_val("t2_div_n", bus_if.div_n, 16'd100);
    check_val("t2_div_d", bus_if.div_d, 8'd7);
    wait_idle();

    // 3: quotient overflow, then the largest in-range quotient
    issue(1, 16'h0A00, 8'h05);
    wait_rsp(lat);
    check_val("t3a_latency", lat, 1);
    wait_idle();
    issue(1, 16'h04FF, 8'h05);
    wait_rsp(lat);
    check_val("t3b_latency", lat, SETTLE_CYC + 1);
    wait_idle();

    // 4: all requesters valid, round-robin from pointer 0, back-to-back spacing
    pulse_reset();
    base = acc_id_q.size();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus_if.req_n[16*i +: 16] = 16'(1000 + 37 * i);
      bus_if.req_d[8*i +: 8]   = 8'(10 + i);
    end
    bus_if.req_valid = '1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #1;
      if (acc_id_q.size() >= base + 5) break;
    end
    check_val("t4_accepts", acc_id_q.size() >= base + 5, 1);
    @(posedge clk); #1;
    bus_if.req_valid = '0;
    if (acc_id_q.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) begin
        check_val($sformatf("t4_grant%0d", k), acc_id_q[base + k], k % NUM_REQ);
        if (k > 0)
          check_val($sformatf("t4_spacing%0d", k),
                    acc_cyc_q[base + k] - acc_cyc_q[base + k - 1], SETTLE_CYC + 2);
      end
    end
    wait_idle();

    // 5: consumer stalls for 5 cycles in RESP
    bus_if.rsp_ready = 1'b0;
    issue(0, 16'd500, 8'd7);
    bus_if.req_valid[3] = 1'b1;
    wait_rsp(lat);
    for (int t = 0; t < 5; t++) begin
      check_val("t5_rsp_valid", bus_if.rsp_valid, 1);
      check_val("t5_rsp_q", bus_if.rsp_q, 8'd71);
      check_val("t5_rsp_r", bus_if.rsp_r, 8'd3);
      check_val("t5_rsp_id", bus_if.rsp_id, 0);
      check_val("t5_req_ready", bus_if.req_ready, 0);
      check_val("t5_busy", bus_if.busy, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus_if.rsp_ready    = 1'b1;
    bus_if.req_valid[3] = 1'b0;
    wait_idle();

    // 6: reset mid-WAIT aborts without a response and restores pointer 0
    issue(1, 16'd300, 8'd9);
    rst = 1'b1;
    if (sb.size() > 0) void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("t6");
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check_val("t6_no_rsp", bus_if.rsp_valid, 0);
    end
    @(posedge clk); #1;
    base = acc_id_q.size();
    bus_if.req_n[15:0]  = 16'd77;
    bus_if.req_d[7:0]   = 8'd5;
    bus_if.req_n[47:32] = 16'd88;
    bus_if.req_d[23:16] = 8'd6;
    bus_if.req_valid    = 4'b0101;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk); #1;
      if (acc_id_q.size() > base) break;
    end
    check_val("t6_accept", acc_id_q.size() > base, 1);
    if (acc_id_q.size() > base) check_val("t6_ptr_reset_grant", acc_id_q[base], 0);
    @(posedge clk); #1;
    bus_if.req_valid = '0;
    wait_idle();

    repeat (5) @(posedge clk);
    check_val("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
